// File: rtl/chip_pkg.sv
// Shared constants and FSM encoding for the single-tile Sobel edge engine.
package chip_pkg;
  localparam int TILE_W = 20;
  localparam int OUT_W  = 18;
  localparam int WORDS  = 80;
  localparam int PIX_W  = 5;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_OUT  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/chip_sobel_3x3.sv
// Combinational 3x3 Sobel edge detector: |Gx| + |Gy| compared against THRESH.
// Window pixel k = row*3 + col sits at win_dat[k*BIT_LENGTH +: BIT_LENGTH].
module sobel_3x3 #(
  parameter int BIT_LENGTH = 5,
  parameter int THRESH     = 64
) (
  input  logic [9*BIT_LENGTH-1:0] win_dat,
  output logic                    edge_bit
);
  // Four extra bits hold a signed sum of four full-scale pixels.
  localparam int W = BIT_LENGTH + 4;
  localparam logic [W:0] THR = THRESH[W:0];

  logic signed [W-1:0] p [9];
  logic signed [W-1:0] gx, gy, ax, ay;
  logic        [W:0]   mag;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      p[k] = {4'b0000, win_dat[k*BIT_LENGTH +: BIT_LENGTH]};
    end
    gx = (p[2] + p[5] + p[5] + p[8]) - (p[0] + p[3] + p[3] + p[6]);
    gy = (p[6] + p[7] + p[7] + p[8]) - (p[0] + p[1] + p[1] + p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    edge_bit = (mag >= THR);
  end
endmodule

// File: rtl/chip.sv
// Tile edge engine: loads a 20x20 tile five pixels per clock, then streams the
// 18x18 interior edge map one pixel per clock under readable; no stall on either side.
module chip
  import chip_pkg::*;
#(
  parameter int BIT_LENGTH = PIX_W,
  parameter int THRESH     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIT_LENGTH-1:0] pixel_in0,
  input  logic [BIT_LENGTH-1:0] pixel_in1,
  input  logic [BIT_LENGTH-1:0] pixel_in2,
  input  logic [BIT_LENGTH-1:0] pixel_in3,
  input  logic [BIT_LENGTH-1:0] pixel_in4,
  input  logic                  load_end,
  output logic                  edge_out,
  output logic                  readable
);
  localparam int NPIX = TILE_W * TILE_W;

  state_e                state_q, state_d;
  logic [6:0]            wcnt_q, wcnt_d;
  logic [4:0]            row_q, row_d, col_q, col_d;
  logic [BIT_LENGTH-1:0] mem_q [NPIX];
  logic [BIT_LENGTH-1:0] mem_d [NPIX];
  logic [BIT_LENGTH-1:0] pix_bus [5];
  logic [8:0]            word_base;
  logic [8:0]            center;
  logic [8:0]            idx;
  logic [9*BIT_LENGTH-1:0] win_dat;
  logic                  sob_edge;

  always_comb begin
    pix_bus[0] = pixel_in0;
    pix_bus[1] = pixel_in1;
    pix_bus[2] = pixel_in2;
    pix_bus[3] = pixel_in3;
    pix_bus[4] = pixel_in4;
    word_base  = 9'(wcnt_q[6:2]) * 9'(TILE_W) + 9'(wcnt_q[1:0]) * 9'd5;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    row_d   = row_q;
    col_d   = col_q;
    mem_d   = mem_q;
    case (state_q)
      ST_LOAD: begin
        if (wcnt_q < 7'(WORDS)) begin
          for (int n = 0; n < 5; n++) begin
            mem_d[word_base + 9'(n)] = pix_bus[n];
          end
          wcnt_d = wcnt_q + 7'd1;
        end
        if (load_end) begin
          // Word 79 is never sent; its pixels are defined as zero.
          for (int n = 0; n < 5; n++) begin
            mem_d[9'(NPIX - 5) + 9'(n)] = '0;
          end
          state_d = ST_OUT;
          row_d   = 5'd1;
          col_d   = 5'd1;
        end
      end
      ST_OUT: begin
        if (col_q == 5'(OUT_W)) begin
          col_d = 5'd1;
          if (row_q == 5'(OUT_W)) begin
            state_d = ST_DONE;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  // Window around (row,col); out-of-tile taps (only reachable outside OUT) read zero.
  always_comb begin
    win_dat = '0;
    idx     = '0;
    center  = 9'(row_q) * 9'(TILE_W) + 9'(col_q);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        idx = center + 9'(i * TILE_W + j) - 9'(TILE_W + 1);
        win_dat[(i*3+j)*BIT_LENGTH +: BIT_LENGTH] = (idx < 9'(NPIX)) ? mem_q[idx] : '0;
      end
    end
  end

  sobel_3x3 #(
    .BIT_LENGTH(BIT_LENGTH),
    .THRESH    (THRESH)
  ) u_sobel (
    .win_dat (win_dat),
    .edge_bit(sob_edge)
  );

  assign readable = (state_q == ST_OUT);
  assign edge_out = readable & sob_edge;
endmodule

// File: tb/tb_chip.sv
// Bench for chip: directed tiles, a software Sobel model with zero-filled word 79,
// and a per-cycle compare of readable/edge_out on the falling edge.
module tb_chip;
  localparam int TH   = 64;
  localparam int NOUT = 324;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pin0 = '0, pin1 = '0, pin2 = '0, pin3 = '0, pin4 = '0;
  logic       load_end = 1'b0;
  logic       edge_out, readable;

  int tile  [400];
  int mtile [400];
  bit exp_map [NOUT];
  int exp_left  = 0;
  bit m_loading = 1'b1;
  int model_ones = 0;
  int tests = 0, fails = 0;
  int run_len = 0, run_ones = 0;

  always #5 clk = ~clk;

  chip #(.BIT_LENGTH(5), .THRESH(TH)) dut (
    .clk(clk), .reset(reset),
    .pixel_in0(pin0), .pixel_in1(pin1), .pixel_in2(pin2),
    .pixel_in3(pin3), .pixel_in4(pin4),
    .load_end(load_end), .edge_out(edge_out), .readable(readable)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int px(input int r, input int c);
    return mtile[r*20 + c];
  endfunction

  // Direct transcription of the Sobel equations over the modelled tile.
  task automatic build_map();
    int gx, gy, mag;
    model_ones = 0;
    for (int r = 1; r <= 18; r++) begin
      for (int c = 1; c <= 18; c++) begin
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        exp_map[(r-1)*18 + (c-1)] = (mag >= TH);
        if (mag >= TH) model_ones++;
      end
    end
  endtask

  // Transaction-level model: a load ends on load_end, then 324 outputs follow.
  always @(posedge clk) begin
    if (reset) begin
      exp_left  = 0;
      m_loading = 1'b1;
    end else if (m_loading && load_end) begin
      m_loading = 1'b0;
      for (int i = 0; i < 400; i++) mtile[i] = (i >= 395) ? 0 : tile[i];
      build_map();
      exp_left = NOUT;
    end else if (exp_left > 0) begin
      exp_left = exp_left - 1;
    end
  end

  always @(negedge clk) begin
    check("readable", int'(readable), (exp_left > 0) ? 1 : 0);
    if (exp_left > 0) begin
      check($sformatf("edge_out[%0d]", NOUT - exp_left), int'(edge_out), int'(exp_map[NOUT - exp_left]));
    end else begin
      check("edge_out_idle", int'(edge_out), 0);
    end
    if (readable) begin
      run_len++;
      run_ones += int'(edge_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input bit hold);
    int r, c0;
    run_len  = 0;
    run_ones = 0;
    for (int k = 0; k < 79; k++) begin
      r  = k / 4;
      c0 = 5 * (k % 4);
      pin0 = 5'(tile[r*20 + c0]);
      pin1 = 5'(tile[r*20 + c0 + 1]);
      pin2 = 5'(tile[r*20 + c0 + 2]);
      pin3 = 5'(tile[r*20 + c0 + 3]);
      pin4 = 5'(tile[r*20 + c0 + 4]);
      load_end = (k == 78);
      tick();
    end
    load_end = hold;
  endtask

  task automatic fill_uniform(input int v);
    for (int i = 0; i < 400; i++) tile[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 400; i++) tile[i] = int'($urandom_range(0, 31));
  endtask

  initial begin
    int cnt;
    @(negedge clk);
    check("reset_readable", int'(readable), 0);
    check("reset_edge", int'(edge_out), 0);
    tick();
    reset = 1'b0;

    // Uniform 10: no edges anywhere.
    fill_uniform(10);
    load(1'b0);
    check("u10_model_ones", model_ones, 0);
    repeat (330) tick();
    check("u10_run_len", run_len, 324);
    check("u10_run_ones", run_ones, 0);

    // Uniform 31: only the zero-filled corner makes edges.
    do_reset();
    fill_uniform(31);
    load(1'b0);
    check("u31_model_ones", model_ones, 4);
    for (int c = 15; c <= 18; c++) check($sformatf("u31_model_r18c%0d", c), int'(exp_map[17*18 + c - 1]), 1);
    check("u31_model_r18c14", int'(exp_map[17*18 + 13]), 0);
    repeat (330) tick();
    check("u31_run_len", run_len, 324);
    check("u31_run_ones", run_ones, 4);

    // Vertical step at col 10.
    do_reset();
    for (int i = 0; i < 400; i++) tile[i] = ((i % 20) >= 10) ? 31 : 0;
    load(1'b0);
    cnt = 0;
    for (int i = 0; i < 17*18; i++) cnt += int'(exp_map[i]);
    check("step_model_ones_r1_17", cnt, 34);
    check("step_model_r1c8", int'(exp_map[7]), 0);
    check("step_model_r1c9", int'(exp_map[8]), 1);
    check("step_model_r1c10", int'(exp_map[9]), 1);
    check("step_model_r1c11", int'(exp_map[10]), 0);
    repeat (330) tick();
    check("step_run_len", run_len, 324);

    // load_end held for 400 cycles through OUT and DONE.
    do_reset();
    fill_random();
    load(1'b1);
    repeat (400) tick();
    load_end = 1'b0;
    check("hold_run_len", run_len, 324);
    check("hold_run_ones", run_ones, model_ones);

    // Abort after 100 outputs, then a full reload.
    do_reset();
    fill_random();
    load(1'b0);
    repeat (99) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_run_len", run_len, 100);
    fill_random();
    load(1'b0);
    repeat (330) tick();
    check("reload_run_len", run_len, 324);
    check("reload_run_ones", run_ones, model_ones);

    // Six back-to-back random tiles.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      fill_random();
      load(1'b0);
      repeat (326) tick();
      check($sformatf("b2b%0d_run_len", t), run_len, 324);
      check($sformatf("b2b%0d_run_ones", t), run_ones, model_ones);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
